mm_tile_loader: RTL

Parametrised, latency-compensating loader that streams a tile of up to `NUM_CH` channels × `num_words` 32-bit words from an external BRAM port into the per-channel on-chip A/W RAMs of the systolic system. It generalises the fixed one-cycle BRAM-read delay path of the matmul top level in three ways: configurable read latency, run-time channel count with optional zero padding, and a start/busy/done/abort handshake. It sits between the matmul FSM and `systolic_system`, and one instance is used for each of the activation and weight paths.

---
 rtl/mm_pkg.sv | 25 ++
 rtl/mm_tile_loader_if.sv | 36 +++
 rtl/mm_lat_pipe.sv | 35 +++
 rtl/mm_tile_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matmul tile loader: FSM state encoding,
// BRAM addressing constants and a one-hot channel decode helper.
package mm_pkg;

    localparam int unsigned MM_BRAM_BYTES_PER_WORD = 4;
    localparam int unsigned MM_BRAM_ADDR_W         = 32;
    localparam int unsigned MM_MAX_CH              = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PAD   = 3'd3,
        ST_DONE  = 3'd4
    } mm_state_t;

    // One-hot decode of a channel index; indices at or above num_ch give all zeros.
    function automatic logic [MM_MAX_CH-1:0] onehot(input int unsigned ch, input int unsigned num_ch);
        logic [MM_MAX_CH-1:0] r;
        r = '0;
        if (ch < num_ch && ch < MM_MAX_CH) r = MM_MAX_CH'(1) << ch;
        return r;
    endfunction

endpackage

// File: rtl/mm_tile_loader_if.sv
// Tile loader bus bundle: control handshake, BRAM read port and on-chip RAM write port.
//   master : the loader (drives BRAM address/enable, RAM writes, busy/done)
//   slave  : the surrounding matmul FSM / BRAM / RAM side
interface mm_tile_loader_if
    import mm_pkg::*;
#(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 10,
    parameter int unsigned CH_W           = $clog2(NUM_CH) + 1
);
    logic                        start;
    logic                        abort;
    logic [MM_BRAM_ADDR_W-1:0]   src_base_addr;
    logic [RAM_ADDR_WIDTH-1:0]   dst_base_addr;
    logic [RAM_ADDR_WIDTH:0]     num_words;
    logic [CH_W-1:0]             num_ch;
    logic [MM_BRAM_ADDR_W-1:0]   addr_bram;
    logic                        enable_bram;
    logic [DATA_WIDTH-1:0]       data_out_bram;
    logic [DATA_WIDTH-1:0]       ram_w_data;
    logic [RAM_ADDR_WIDTH-1:0]   ram_w_addr;
    logic [NUM_CH-1:0]           ram_w_en;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, abort, src_base_addr, dst_base_addr, num_words, num_ch, data_out_bram,
        output addr_bram, enable_bram, ram_w_data, ram_w_addr, ram_w_en, busy, done
    );

    modport slave (
        output start, abort, src_base_addr, dst_base_addr, num_words, num_ch, data_out_bram,
        input  addr_bram, enable_bram, ram_w_data, ram_w_addr, ram_w_en, busy, done
    );
endinterface

// File: rtl/mm_lat_pipe.sv
// Fixed-depth valid/payload delay line that tracks in-flight BRAM reads.
//   clk, reset    : clock, async active-high reset (valid bits only)
//   flush         : synchronous clear of every valid bit
//   in_valid/in_payload   : stage-0 input
//   out_valid/out_payload : value entered DEPTH cycles earlier
module mm_lat_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned PW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    output logic [PW-1:0] out_payload
);
    logic [DEPTH-1:0]    vld_q;
    logic [DEPTH*PW-1:0] pl_q;

    // Valid chain: shift toward the tail, cleared on reset or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      vld_q <= '0;
        else if (flush) vld_q <= '0;
        else            vld_q <= DEPTH'({vld_q, in_valid});
    end

    // Payload chain carries no reset; it is qualified by the valid chain.
    always_ff @(posedge clk) begin
        pl_q <= (DEPTH*PW)'({pl_q, in_payload});
    end

    assign out_valid   = vld_q[DEPTH-1];
    assign out_payload = pl_q[DEPTH*PW-1 -: PW];
endmodule

// File: rtl/mm_tile_loader.sv
// Streams num_ch x num_words BRAM words into per-channel on-chip RAMs,
// compensating a configurable BRAM read latency.
//   clk, reset : clock, async active-high reset
//   bus        : mm_tile_loader_if.master (start/abort/config in, BRAM read, RAM write, busy/done)
// Optional feature macro MM_TILE_LOADER_ZERO_PAD_EN: zero-fills channels num_ch..NUM_CH-1.
// RAM addresses wrap modulo 2^RAM_ADDR_WIDTH, so RAM_SIZE is expected to be a power of two.
module mm_tile_loader
    import mm_pkg::*;
#(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_SIZE       = 1024,
    parameter int unsigned RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    mm_tile_loader_if.master  bus
);
    localparam int unsigned CH_W     = $clog2(NUM_CH) + 1;
    localparam int unsigned CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NW_W     = RAM_ADDR_WIDTH + 1;
    localparam int unsigned DR_W     = $clog2(READ_LATENCY + 1);
    localparam int unsigned PL_W     = CH_IDX_W + RAM_ADDR_WIDTH;

    mm_state_t                 state_q, state_d;
    logic [MM_BRAM_ADDR_W-1:0] addr_q, addr_d;
    logic                      en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic [RAM_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [NW_W-1:0]           nw_q, nw_d, w_q, w_d, w_adv;
    logic [CH_W-1:0]           nch_q, nch_d, ch_q, ch_d, ch_adv, nch_clamp;
    logic [DR_W-1:0]           dr_q, dr_d;
    logic                      last_w, issue_last, abort_take;
    logic                      pipe_vld;
    logic [PL_W-1:0]           pipe_in, pipe_out;

    assign nch_clamp  = (bus.num_ch > CH_W'(NUM_CH)) ? CH_W'(NUM_CH) : bus.num_ch;
    assign last_w     = (w_q == nw_q - NW_W'(1));
    assign issue_last = last_w && (ch_q == nch_q - CH_W'(1));
    assign abort_take = bus.abort && (state_q != ST_IDLE) && (state_q != ST_DONE);

    // Channel-major walk shared by ISSUE and PAD: rolls into the next channel after the last word.
    assign w_adv  = last_w ? '0 : w_q + NW_W'(1);
    assign ch_adv = last_w ? ch_q + CH_W'(1) : ch_q;

`ifdef MM_TILE_LOADER_ZERO_PAD_EN
    logic pad_last;
    assign pad_last = last_w && (ch_q == CH_W'(NUM_CH - 1));
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        nw_d    = nw_q;
        nch_d   = nch_q;
        ch_d    = ch_q;
        w_d     = w_q;
        dr_d    = dr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.src_base_addr;
                    dst_d   = bus.dst_base_addr;
                    nw_d    = bus.num_words;
                    nch_d   = nch_clamp;
                    ch_d    = '0;
                    w_d     = '0;
                    state_d = (bus.num_words == '0 || nch_clamp == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                addr_d = addr_q + MM_BRAM_ADDR_W'(MM_BRAM_BYTES_PER_WORD);
                ch_d   = ch_adv;
                w_d    = w_adv;
                if (issue_last) begin
                    state_d = ST_DRAIN;
                    dr_d    = '0;
                end
            end
            ST_DRAIN: begin
                dr_d = dr_q + DR_W'(1);
                if (dr_q == DR_W'(READ_LATENCY - 1)) begin
`ifdef MM_TILE_LOADER_ZERO_PAD_EN
                    // ch/w already point at channel num_ch, word 0 after the last read.
                    state_d = (nch_q < CH_W'(NUM_CH)) ? ST_PAD : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef MM_TILE_LOADER_ZERO_PAD_EN
            ST_PAD: begin
                ch_d = ch_adv;
                w_d  = w_adv;
                if (pad_last) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_take) state_d = ST_IDLE;
        en_d   = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dst_q   <= '0;
            nw_q    <= '0;
            nch_q   <= '0;
            ch_q    <= '0;
            w_q     <= '0;
            dr_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dst_q   <= dst_d;
            nw_q    <= nw_d;
            nch_q   <= nch_d;
            ch_q    <= ch_d;
            w_q     <= w_d;
            dr_q    <= dr_d;
        end
    end

    // Each issued read carries its destination channel and RAM address down the latency line.
    assign pipe_in = {ch_q[CH_IDX_W-1:0], dst_q + w_q[RAM_ADDR_WIDTH-1:0]};

    mm_lat_pipe #(
        .DEPTH (READ_LATENCY),
        .PW    (PL_W)
    ) u_lat_pipe (
        .clk         (clk),
        .reset       (reset),
        .flush       (abort_take),
        .in_valid    (state_q == ST_ISSUE),
        .in_payload  (pipe_in),
        .out_valid   (pipe_vld),
        .out_payload (pipe_out)
    );

    assign bus.addr_bram   = addr_q;
    assign bus.enable_bram = en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // RAM write port: pipeline tail during data phase, zero writes during PAD, idle otherwise.
    always_comb begin
        bus.ram_w_en   = '0;
        bus.ram_w_addr = '0;
        bus.ram_w_data = '0;
        if (pipe_vld) begin
            bus.ram_w_en   = NUM_CH'(onehot(32'(pipe_out[PL_W-1 -: CH_IDX_W]), NUM_CH));
            bus.ram_w_addr = pipe_out[RAM_ADDR_WIDTH-1:0];
            bus.ram_w_data = bus.data_out_bram;
        end
`ifdef MM_TILE_LOADER_ZERO_PAD_EN
        else if (state_q == ST_PAD) begin
            bus.ram_w_en   = NUM_CH'(onehot(32'(ch_q), NUM_CH));
            bus.ram_w_addr = dst_q + w_q[RAM_ADDR_WIDTH-1:0];
        end
`endif
    end
endmodule
